mod_addsub_pipe: RTL and testbench
==================================

Name: mod_addsub_pipe

Overview:
- Parametrised, two-stage pipelined modular add/subtract unit for the NTT datapath.
- Each transaction carries its own modulus q, a mode and a tag.
- Butterfly mode returns a+b and a-b mod q in the same beat.
- Valid/ready handshakes on both sides; it can sit between the twiddle multiplier and the memory write-back stage.

Parameters:
- DATA_W, 32, operand and modulus width in bits.
- TAG_W, 8, width of the opaque tag carried alongside each transaction.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept an input this cycle
- in_mode  in  2  operation: 00 ADD, 01 SUB, 10 BFLY, 11 NEG
- in_q  in  DATA_W  modulus; 2 <= q < 2^DATA_W
- in_a  in  DATA_W  operand a; required a < q
- in_b  in  DATA_W  operand b; required b < q (ignored for NEG)
- in_tag  in  TAG_W  tag, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_res0  out  DATA_W  primary result
- out_res1  out  DATA_W  secondary result (BFLY only, else 0)
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  range-error flag (see Optional Feature; tied 0 otherwise)

Behaviour:
- Clock and reset: clk rising edge; reset is synchronous, active-high.
- Handshakes: transfer occurs on valid&ready at each port.
  - in_valid must not depend on in_ready.
  - Once out_valid is high, out_* hold stable until out_ready.
- Stage 1 (S1) registers s1_valid, mode, q, tag, sum = a+b (DATA_W+1 bits) and diff = a-b (DATA_W+1 bits, MSB = borrow).
- Stage 2 (S2) registers the reduced results, which drive out_* directly:
  - ADD: res0 = (sum >= q) ? sum-q : sum; res1 = 0.
  - SUB: res0 = borrow ? diff+q : diff (truncated to DATA_W); res1 = 0.
  - BFLY: res0 = ADD result; res1 = SUB result.
  - NEG: res0 = (a == 0) ? 0 : q-a; res1 = 0. S1 computes diff = q-a for this mode.
  - All comparisons use the full DATA_W+1-bit sum, so there is no overflow at q near 2^DATA_W.
- Flow control:
  - adv2 = ~s2_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1
  - S2 loads from S1 when adv2; s2_valid <= s1_valid.
  - S1 loads from the inputs when adv1; s1_valid <= in_valid.
  - A stage whose advance signal is low holds all of its registers.
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid when unstalled.
  - Full throughput of 1 transaction per cycle.
  - Order is preserved.
- Capacity: 2 transactions in flight. With out_ready low and both stages full, in_ready = 0. Simultaneous accept and emit in the same cycle is legal.
- Reset: s1_valid, s2_valid, out_valid = 0; out_res0, out_res1, out_tag, out_err = 0. in_ready is 1 in the first cycle after reset. A reset mid-operation discards all in-flight transactions with no output.
- Out-of-range operands (a >= q or b >= q): the result is undefined, but no hang and no protocol violation.

Optional Feature:
- Macro: MODADDSUB_RANGE_CHECK_EN.
- Defined:
  - S1 also registers err = (a >= q) | (b >= q && mode != NEG).
  - The flag travels with the transaction; out_err is valid with out_valid.
  - When err is set, res0 and res1 are forced to 0.
- Not defined:
  - No comparators are instantiated.
  - out_err is tied to 0.
  - Results for out-of-range operands are undefined.

Test Plan:
- All cases use DATA_W=16, q=12289 unless stated.
- BFLY, a=12000, b=1000, out_ready=1 -> 2 cycles later out_res0=711, out_res1=11000, tag echoed.
- SUB a=5, b=7 -> res0=12287. NEG a=0 -> res0=0. NEG a=1 -> res0=12288. ADD a=b=12288 -> res0=12287.
- q=65521, ADD a=b=65520 (sum overflows 16 bits) -> res0=65519. BFLY same -> res1=0.
- Back-to-back stream of 100 random ops with out_ready=1 -> in_ready constantly 1, one result per cycle, in order, matching the reference model.
- Hold out_ready=0 while issuing 3 ops -> in_ready drops after 2 accepted. out_res0 and out_tag stay stable. Release -> all 3 emerge in order, none lost or duplicated.
- Assert reset for 1 cycle with both stages full -> out_valid=0 next cycle, no stale result afterwards. With MODADDSUB_RANGE_CHECK_EN, a=12289 -> out_err=1, res0=0.

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular add/sub/butterfly/negate; each op carries its own q and tag.
// Latency 2 cycles, 1 op/cycle; a stalled stage holds, in_ready = S1 can advance.
// MODADDSUB_RANGE_CHECK_EN adds a per-op operand range flag (out_err) that zeroes results.
module mod_addsub_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_q,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res0,
    output logic [DATA_W-1:0] out_res1,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_BFLY = 2'b10,
        MODE_NEG  = 2'b11
    } mode_e;

    typedef struct packed {
        mode_e             mode;
        logic [DATA_W-1:0] q;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W:0]   sum;
        logic [DATA_W:0]   diff;
    } s1_t;

    logic s1_valid;
    logic s2_valid;
    logic adv1;
    logic adv2;
    s1_t  s1;
    s1_t  s1_d;

    assign adv2      = ~s2_valid | out_ready;
    assign adv1      = ~s1_valid | adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // Stage 1: raw sum and difference, one extra bit so q near 2^DATA_W cannot overflow
    always_comb begin
        s1_d.mode = mode_e'(in_mode);
        s1_d.q    = in_q;
        s1_d.tag  = in_tag;
        s1_d.sum  = {1'b0, in_a} + {1'b0, in_b};
        if (s1_d.mode == MODE_NEG) begin
            s1_d.diff = {1'b0, in_q} - {1'b0, in_a};
        end else begin
            s1_d.diff = {1'b0, in_a} - {1'b0, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            s1       <= s1_d;
        end
    end

`ifdef MODADDSUB_RANGE_CHECK_EN
    logic s1_err;
    logic err_d;

    assign err_d = (in_a >= in_q) | ((in_b >= in_q) && (in_mode != 2'b11));

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_err <= 1'b0;
        end else if (adv1) begin
            s1_err <= err_d;
        end
    end
`endif

    // Stage 2: single conditional correction by q
    logic [DATA_W-1:0] add_red;
    logic [DATA_W-1:0] sub_red;
    logic [DATA_W-1:0] neg_red;
    logic [DATA_W-1:0] res0_d;
    logic [DATA_W-1:0] res1_d;

    always_comb begin
        add_red = (s1.sum >= {1'b0, s1.q}) ? (s1.sum[DATA_W-1:0] - s1.q) : s1.sum[DATA_W-1:0];
        sub_red = s1.diff[DATA_W] ? (s1.diff[DATA_W-1:0] + s1.q) : s1.diff[DATA_W-1:0];
        // q - a equals q exactly when a == 0, and -0 mod q is 0
        neg_red = (s1.diff == {1'b0, s1.q}) ? '0 : s1.diff[DATA_W-1:0];
        res0_d  = '0;
        res1_d  = '0;
        case (s1.mode)
            MODE_ADD:  res0_d = add_red;
            MODE_SUB:  res0_d = sub_red;
            MODE_BFLY: begin
                res0_d = add_red;
                res1_d = sub_red;
            end
            MODE_NEG:  res0_d = neg_red;
            default:   res0_d = '0;
        endcase
`ifdef MODADDSUB_RANGE_CHECK_EN
        if (s1_err) begin
            res0_d = '0;
            res1_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            out_res0 <= '0;
            out_res1 <= '0;
            out_tag  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            out_res0 <= res0_d;
            out_res1 <= res1_d;
            out_tag  <= s1.tag;
        end
    end

`ifdef MODADDSUB_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_err <= 1'b0;
        end else if (adv2) begin
            out_err <= s1_err;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Randomized + directed bench for mod_addsub_pipe (DATA_W=16) with a scoreboard reference model.
module tb_mod_addsub_pipe;

    localparam int DW = 16;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [DW-1:0] in_q;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_res0;
    logic [DW-1:0] out_res1;
    logic [TW-1:0] out_tag;
    logic          out_err;

    mod_addsub_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_q(in_q), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res0(out_res0), .out_res1(out_res1), .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        longint   r0;
        longint   r1;
        logic [TW-1:0] tag;
        logic     err;
    } exp_t;

    exp_t exp_q[$];
    int   n_out = 0;

    // Reference: plain modular arithmetic on integers
    function automatic exp_t model(input logic [1:0] m, input longint q, input longint a,
                                   input longint b, input logic [TW-1:0] t);
        exp_t e;
        longint add_v, sub_v, neg_v;
        add_v = (a + b) % q;
        sub_v = (((a - b) % q) + q) % q;
        neg_v = (q - a) % q;
        e.tag = t;
        e.r1  = 0;
        case (m)
            2'b00: e.r0 = add_v;
            2'b01: e.r0 = sub_v;
            2'b10: begin e.r0 = add_v; e.r1 = sub_v; end
            default: e.r0 = neg_v;
        endcase
`ifdef MODADDSUB_RANGE_CHECK_EN
        e.err = (a >= q) || (b >= q && m != 2'b11);
        if (e.err) begin
            e.r0 = 0;
            e.r1 = 0;
        end
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard: transfers seen at negedge complete on the following posedge
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", longint'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_res0", out_res0, e.r0);
                    chk("sb_res1", out_res1, e.r1);
                    chk("sb_tag", out_tag, e.tag);
                    chk("sb_err", out_err, e.err);
                end
                n_out++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_mode, in_q, in_a, in_b, in_tag));
        end
    end

    task automatic drive(input logic [1:0] m, input int q, input int a, input int b,
                         input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_mode  = m;
        in_q     = DW'(q);
        in_a     = DW'(a);
        in_b     = DW'(b);
        in_tag   = t;
    endtask

    task automatic rand_op(output logic [1:0] m, output int q, output int a, output int b);
        m = 2'($urandom_range(3, 0));
        q = int'($urandom_range(65535, 2));
        a = int'($urandom_range(q - 1, 0));
        b = int'($urandom_range(q - 1, 0));
    endtask

    // Single op into an empty pipe: checks latency and literal results
    task automatic do_one(input string nm, input logic [1:0] m, input int q, input int a,
                          input int b, input logic [TW-1:0] t, input int e0, input int e1,
                          input logic e_err);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(m, q, a, b, t);
        @(negedge clk);
        chk({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 2);
        chk({nm, "_res0"}, out_res0, e0);
        chk({nm, "_res1"}, out_res1, e1);
        chk({nm, "_tag"}, out_tag, t);
        chk({nm, "_err"}, out_err, e_err);
    endtask

    logic [1:0]    bm   [3];
    int            bq   [3];
    int            ba   [3];
    int            bb   [3];
    logic [DW-1:0] hold_res0;
    logic [TW-1:0] hold_tag;

    initial begin
        int k, n0, n;
        logic [1:0] m;
        int q, a, b;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = '0;
        in_q      = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res0", out_res0, 0);
        chk("rst_res1", out_res1, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_err", out_err, 0);

        do_one("bfly", 2'b10, 12289, 12000, 1000, 8'h5A, 711, 11000, 1'b0);
        do_one("sub", 2'b01, 12289, 5, 7, 8'h11, 12287, 0, 1'b0);
        do_one("neg0", 2'b11, 12289, 0, 77, 8'h12, 0, 0, 1'b0);
        do_one("neg1", 2'b11, 12289, 1, 0, 8'h13, 12288, 0, 1'b0);
        do_one("add_max", 2'b00, 12289, 12288, 12288, 8'h14, 12287, 0, 1'b0);
        do_one("add_ovf", 2'b00, 65521, 65520, 65520, 8'h15, 65519, 0, 1'b0);
        do_one("bfly_ovf", 2'b10, 65521, 65520, 65520, 8'h16, 65519, 0, 1'b0);
`ifdef MODADDSUB_RANGE_CHECK_EN
        do_one("range_a", 2'b00, 12289, 12289, 3, 8'h17, 0, 0, 1'b1);
`endif

        // Back-to-back stream of 100 random ops
        @(posedge clk); #1;
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            rand_op(m, q, a, b);
            drive(m, q, a, b, 8'(i));
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1);
            if (i >= 2) chk("stream_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_tail0", out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_tail1", out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_idle", out_valid, 0);
        @(posedge clk); #1;
        chk("stream_count", n_out - n0, 100);

        // Backpressure: 3 ops against a stalled sink
        for (int i = 0; i < 3; i++) begin
            rand_op(m, q, a, b);
            bm[i] = m; bq[i] = q; ba[i] = a; bb[i] = b;
        end
        n0 = n_out;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (k < 3) drive(bm[k], bq[k], ba[k], bb[k], 8'(8'h40 + k));
            @(negedge clk);
            if (c == 3) begin
                hold_res0 = out_res0;
                hold_tag  = out_tag;
            end
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_accepted", k, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_res0_stable", out_res0, hold_res0);
        chk("bp_tag_stable", out_tag, hold_tag);
        chk("bp_tag_first", out_tag, 8'h40);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (k < 3 && n < 10) begin
            drive(bm[k], bq[k], ba[k], bb[k], 8'(8'h40 + k));
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", k, 3);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", n_out - n0, 3);
        chk("bp_sb_empty", exp_q.size(), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_op(m, q, a, b);
            drive(m, q, a, b, 8'(8'h70 + i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("prerst_out_valid", out_valid, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_res0", out_res0, 0);
        chk("midrst_tag", out_tag, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_stale", out_valid, 0);
        end
        chk("end_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
